// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory read channel between the fetch stage (master) and memory (slave).
// Single outstanding request: req held with a stable addr until ack returns rdata.
interface instr_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Fetch stage with IF/ID register, one-entry skid buffer and redirect draining.
// Define IF_PERF_CNT_EN to add the fetch_cnt/bubble_cnt performance counters.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  instr_fetch_stage_if.master        imem,
  input  logic                       stall_d,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic [31:0]                instr_d,
  output logic [31:0]                pc_d,
  output logic                       valid_d
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]                fetch_cnt,
  output logic [31:0]                bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01,
    DRAIN = 2'b10
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pend_pc, pend_pc_nxt;
  logic [31:0] skid, skid_nxt;
  logic [31:0] skid_pc, skid_pc_nxt;
  logic [31:0] instr_nxt;
  logic [31:0] pc_d_nxt;
  logic        valid_nxt;
  logic        fetch_accept;
  logic [31:0] pc_seq;
  logic        out_free;

  assign pc_seq   = pc + PC_INC;
  assign out_free = !valid_d || !stall_d;

  // Request is gated by reset so memory sees no read while rst_n is low.
  assign imem.imem_req  = rst_n && (state != HOLD);
  assign imem.imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      pend_pc <= 32'd0;
      skid    <= 32'd0;
      skid_pc <= 32'd0;
      instr_d <= 32'd0;
      pc_d    <= 32'd0;
      valid_d <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      pend_pc <= pend_pc_nxt;
      skid    <= skid_nxt;
      skid_pc <= skid_pc_nxt;
      instr_d <= instr_nxt;
      pc_d    <= pc_d_nxt;
      valid_d <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    pend_pc_nxt  = pend_pc;
    skid_nxt     = skid;
    skid_pc_nxt  = skid_pc;
    instr_nxt    = instr_d;
    pc_d_nxt     = pc_d;
    valid_nxt    = valid_d;
    fetch_accept = 1'b0;

    unique case (state)
      FETCH: begin
        if (imem.imem_ack) begin
          if (redirect) begin
            pc_nxt    = redirect_pc;
            valid_nxt = 1'b0;
          end else begin
            fetch_accept = 1'b1;
            pc_nxt       = pc_seq;
            if (out_free) begin
              instr_nxt = imem.imem_rdata;
              pc_d_nxt  = pc_seq;
              valid_nxt = 1'b1;
            end else begin
              skid_nxt    = imem.imem_rdata;
              skid_pc_nxt = pc_seq;
              state_nxt   = HOLD;
            end
          end
        end else if (redirect) begin
          // The outstanding read cannot be cancelled; remember the target until it returns.
          pend_pc_nxt = redirect_pc;
          valid_nxt   = 1'b0;
          state_nxt   = DRAIN;
        end else if (!stall_d) begin
          valid_nxt = 1'b0;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_nxt    = redirect_pc;
          valid_nxt = 1'b0;
          state_nxt = FETCH;
        end else if (!stall_d) begin
          instr_nxt = skid;
          pc_d_nxt  = skid_pc;
          valid_nxt = 1'b1;
          state_nxt = FETCH;
        end
      end

      DRAIN: begin
        valid_nxt = 1'b0;
        if (imem.imem_ack) begin
          pc_nxt    = redirect ? redirect_pc : pend_pc;
          state_nxt = FETCH;
        end else if (redirect) begin
          pend_pc_nxt = redirect_pc;
        end
      end

      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else begin
      if (fetch_accept) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (!valid_d && !stall_d) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_accept;
  assign unused_accept = fetch_accept;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: a variable-latency memory returns addr|0xA000,
// expected decode words are queued at accepted acks and popped as they leave the IF/ID register.
`timescale 1ns/1ps
module tb_instr_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        stall_d;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        valid_d;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  instr_fetch_stage_if imem ();

  instr_fetch_stage #(
    .RESET_PC (RESET_PC),
    .PC_INC   (32'd4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem.master),
    .stall_d     (stall_d),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .valid_d     (valid_d)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .bubble_cnt  (bubble_cnt)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int lat = 0;
  int wait_cnt;
  int popped = 0;

  logic [63:0] sb_q[$];
  logic [31:0] exp_addr = RESET_PC;
  logic [31:0] pend_addr = 32'd0;
  bit          draining = 1'b0;
  logic [31:0] model_fetch = 32'd0;
  logic [31:0] model_bubble = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack once the request has waited lat cycles (same cycle when lat is 0).
  always_comb begin
    imem.imem_ack   = imem.imem_req && (wait_cnt >= lat);
    imem.imem_rdata = imem.imem_addr | 32'h0000_A000;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (imem.imem_req && !imem.imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic stall, input logic redir, input logic [31:0] rpc, input int cycles);
    stall_d     = stall;
    redirect    = redir;
    redirect_pc = rpc;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: acts at the negedge on what the coming posedge will do.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_addr     = RESET_PC;
      draining     = 1'b0;
      model_fetch  = 32'd0;
      model_bubble = 32'd0;
    end else begin
      if (!valid_d && !stall_d) model_bubble = model_bubble + 32'd1;
      if (valid_d && (!stall_d || redirect)) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_underflow", 64'(sb_q.size()), 64'd1);
        end else begin
          checkOutput("decode_word", {instr_d, pc_d}, sb_q.pop_front());
          popped++;
        end
      end
      if (imem.imem_req) checkOutput("imem_addr", 64'(imem.imem_addr), 64'(exp_addr));
      if (imem.imem_ack) begin
        if (redirect) begin
          sb_q.delete();
          exp_addr = redirect_pc;
          draining = 1'b0;
        end else if (draining) begin
          exp_addr = pend_addr;
          draining = 1'b0;
        end else begin
          sb_q.push_back({exp_addr | 32'h0000_A000, exp_addr + 32'd4});
          exp_addr    = exp_addr + 32'd4;
          model_fetch = model_fetch + 32'd1;
        end
      end else if (redirect) begin
        sb_q.delete();
        if (imem.imem_req) begin
          draining  = 1'b1;
          pend_addr = redirect_pc;
        end else begin
          exp_addr = redirect_pc;
        end
      end
    end
  end

  initial begin
    logic [31:0] held_instr;
    logic [31:0] old_addr;
    bit found;

    rst_n = 1'b0;
    stall_d = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'd0;
    #2;
    checkOutput("rst_instr_d", 64'(instr_d), 64'd0);
    checkOutput("rst_pc_d", 64'(pc_d), 64'd0);
    checkOutput("rst_valid_d", 64'(valid_d), 64'd0);
    checkOutput("rst_imem_req", 64'(imem.imem_req), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    checkOutput("rel_req", 64'(imem.imem_req), 64'd1);
    checkOutput("rel_addr", 64'(imem.imem_addr), 64'(RESET_PC));
    @(posedge clk);
    #1;
    checkOutput("first_valid", 64'(valid_d), 64'd1);
    checkOutput("first_pc_d", 64'(pc_d), 64'd4);
    applyStimulus(1'b0, 1'b0, 32'd0, 5);

    // Stall with an ack arriving: the word lands in the skid buffer and requests stop.
    held_instr = instr_d;
    applyStimulus(1'b1, 1'b0, 32'd0, 1);
    checkOutput("hold_req", 64'(imem.imem_req), 64'd0);
    checkOutput("hold_valid", 64'(valid_d), 64'd1);
    applyStimulus(1'b1, 1'b0, 32'd0, 2);
    checkOutput("stall_instr_held", 64'(instr_d), 64'(held_instr));
    applyStimulus(1'b0, 1'b0, 32'd0, 4);

    // Redirect coinciding with an ack.
    applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1);
    checkOutput("redir_valid", 64'(valid_d), 64'd0);
    checkOutput("redir_addr", 64'(imem.imem_addr), 64'h100);
    applyStimulus(1'b0, 1'b0, 32'd0, 1);
    checkOutput("redir_pc_d", 64'(pc_d), 64'h104);
    applyStimulus(1'b0, 1'b0, 32'd0, 3);

    // Three-cycle memory, redirect during wait cycle 1.
    lat = 3;
    applyStimulus(1'b0, 1'b0, 32'd0, 8);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem.imem_req && !imem.imem_ack && wait_cnt == 1) found = 1'b1;
      else applyStimulus(1'b0, 1'b0, 32'd0, 1);
    end
    checkOutput("wait1_reached", 64'(found), 64'd1);
    old_addr = imem.imem_addr;
    applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1);
    redirect = 1'b0;
    checkOutput("drain_valid", 64'(valid_d), 64'd0);
    checkOutput("drain_addr_held", 64'(imem.imem_addr), 64'(old_addr));
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem.imem_ack) found = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'd0, 1);
    end
    checkOutput("drain_ack_seen", 64'(found), 64'd1);
    checkOutput("post_drain_addr", 64'(imem.imem_addr), 64'h200);
    checkOutput("post_drain_valid", 64'(valid_d), 64'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 10);

    // Random stall/redirect traffic on a one-wait memory.
    lat = 1;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'(($urandom_range(0, 2)) == 0), 1'(($urandom_range(0, 15)) == 0),
                    {22'd0, 8'($urandom_range(0, 255)), 2'b00}, 1);
    end
    lat = 0;
    applyStimulus(1'b0, 1'b0, 32'd0, 6);

    // PC wrap at the top of the address space.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8, 1);
    applyStimulus(1'b0, 1'b0, 32'd0, 2);
    checkOutput("wrap_pc_d", 64'(pc_d), 64'd0);
    checkOutput("wrap_addr", 64'(imem.imem_addr), 64'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 3);

`ifdef IF_PERF_CNT_EN
    checkOutput("fetch_cnt", 64'(fetch_cnt), 64'(model_fetch));
    checkOutput("bubble_cnt", 64'(bubble_cnt), 64'(model_bubble));
`endif

    // Asynchronous reset while in HOLD.
    applyStimulus(1'b1, 1'b0, 32'd0, 1);
    checkOutput("pre_rst_hold_req", 64'(imem.imem_req), 64'd0);
    checkOutput("pre_rst_valid", 64'(valid_d), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_instr_d", 64'(instr_d), 64'd0);
    checkOutput("async_pc_d", 64'(pc_d), 64'd0);
    checkOutput("async_valid_d", 64'(valid_d), 64'd0);
    checkOutput("async_req", 64'(imem.imem_req), 64'd0);
    stall_d = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    checkOutput("rerel_addr", 64'(imem.imem_addr), 64'(RESET_PC));
`ifdef IF_PERF_CNT_EN
    checkOutput("rst_fetch_cnt", 64'(fetch_cnt), 64'd0);
    checkOutput("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
`endif
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 32'd0, 6);
    checkOutput("min_delivered", 64'(popped >= 40), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
